// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, queue depth and FSM states of the ALU command sequencer
package alu_seq_pkg;
    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int TAG_W  = 8;
    localparam int DEPTH  = 4;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU drive and response signals of the sequencer
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;
    logic              cmdValid;
    logic              cmdReady;
    logic [DATA_W-1:0] cmdOperandA;
    logic [DATA_W-1:0] cmdOperandB;
    logic [OP_W-1:0]   cmdAluOp;
    logic [DATA_W-1:0] aluOperandA;
    logic [DATA_W-1:0] aluOperandB;
    logic [OP_W-1:0]   aluOp;
    logic [DATA_W-1:0] aluResult;
    logic              rspValid;
    logic              rspReady;
    logic [DATA_W-1:0] rspResult;
    logic [TAG_W-1:0]  rspTag;
    logic              busy;
    modport master (
        output cmdValid, cmdOperandA, cmdOperandB, cmdAluOp, aluResult, rspReady,
        input  cmdReady, aluOperandA, aluOperandB, aluOp, rspValid, rspResult, rspTag, busy
    );
    modport slave (
        input  cmdValid, cmdOperandA, cmdOperandB, cmdAluOp, aluResult, rspReady,
        output cmdReady, aluOperandA, aluOperandB, aluOp, rspValid, rspResult, rspTag, busy
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with occupancy count and flush
module alu_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    // Pointers wrap naturally at DEPTH; a full FIFO refuses a push even when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // Storage is not reset; occupancy alone says which entries are valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, drives the ALU and returns tagged results in order
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = alu_seq_pkg::DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    alu_cmd_sequencer_if.slave bus
);
    localparam int W = 2 * DATA_W + OP_W;
    state_t           state;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     head;
    logic             full;
    logic             empty;
    logic             pop;
    assign bus.cmdReady = rst_n && !full;
    assign bus.busy     = state != IDLE || !empty;
    assign pop          = !flush && !empty && (state == IDLE || (state == RESP && bus.rspReady));
    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (bus.cmdValid && bus.cmdReady),
        .wdata ({bus.cmdOperandA, bus.cmdOperandB, bus.cmdAluOp}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    // Issue the FIFO head, capture its result with the next tag, hold it until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tag             <= '0;
            bus.aluOperandA <= '0;
            bus.aluOperandB <= '0;
            bus.aluOp       <= '0;
            bus.rspValid    <= 1'b0;
            bus.rspResult   <= '0;
            bus.rspTag      <= '0;
        end else if (flush) begin
            state        <= IDLE;
            bus.rspValid <= 1'b0;
        end else begin
            if (pop) {bus.aluOperandA, bus.aluOperandB, bus.aluOp} <= head;
            case (state)
                IDLE: state <= empty ? IDLE : EXEC;
                EXEC: begin
                    bus.rspResult <= bus.aluResult;
                    bus.rspTag    <= tag;
                    bus.rspValid  <= 1'b1;
                    tag           <= tag + 1'b1;
                    state         <= RESP;
                end
                RESP: if (bus.rspReady) begin
                    bus.rspValid <= 1'b0;
                    state        <= empty ? IDLE : EXEC;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
